fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the 16-bit pipelined processor. It owns the PC, drives the instruction-memory read address, and delivers each fetched instruction with its PC to the decode stage. It consumes the PC-select, kill and stall outputs of the control and hazard logic in ID, so it is the producer side of that control loop. An optional return-address stack supplies RET targets.

## Interface
- PC_W, 16, PC and instruction-address width (word addressed)
- INSTR_W, 16, instruction width; opcode is instr[15:12]
- RAS_DEPTH, 8, return-address-stack entries (power of 2; used only with RAS_EN)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- imem_addr  out  PC_W  instruction-memory address, equal to the current PC (combinational)
- imem_data  in  INSTR_W  instruction at imem_addr, valid in the same cycle
- stall  in  1  load-use stall from hazard detection: hold PC and IF/ID
- kill  in  1  redirect taken in ID: flush IF/ID
- pc_src  in  2  next-PC select: 0 = PC+1, 1 = jump_target, 2 = branch_target, 3 = return address
- jump_target  in  PC_W  JMP/CALL target computed in ID
- branch_target  in  PC_W  taken-branch target computed in ID
- ret_addr  in  PC_W  return address from register file (R7)
- id_instr  out  INSTR_W  IF/ID instruction
- id_pc  out  PC_W  IF/ID PC of id_instr
- id_valid  out  1  IF/ID holds a real instruction (0 = bubble)
- ras_miss  out  1  one-cycle pulse: RET popped an empty stack

## Operation
- Reset: PC = 0, id_instr = 0, id_pc = 0, id_valid = 0, ras_miss = 0, stack empty.
- Priority per edge: reset > stall > kill > sequential fetch.
- stall = 1: PC, id_instr, id_pc, id_valid held; kill and pc_src ignored. ID re-resolves the held instruction next cycle.
- kill = 1 (stall = 0): PC <= target selected by pc_src; id_valid <= 0, id_instr <= 0, id_pc <= 0.
- Normal: PC <= PC+1; id_instr <= imem_data, id_pc <= PC, id_valid <= 1.
- pc_src with kill = 0 is ignored; PC+1 always used.
- PC arithmetic modulo 2^PC_W: 0xFFFF + 1 = 0x0000.
- Return address for pc_src = 3: RAS top of stack when RAS_EN is defined and the stack is non-empty, otherwise ret_addr.

## Timing
- Fetch-to-ID latency: 1 cycle. The instruction at PC is in IF/ID after the next edge.
- Redirect penalty: exactly 1 bubble. Kill at edge N gives id_valid = 0 in cycle N+1 and imem_addr = target in cycle N+1. The target instruction is valid in ID in cycle N+2.
- Stall of k cycles holds IF/ID for k cycles. No instruction is lost or duplicated.
- ras_miss is registered. It is high in the cycle after the empty pop, for one cycle.
- Reset is asserted mid-stall or mid-redirect: reset wins and all state returns to reset values.

## Configuration
- FETCH_RAS_EN defined:
  - Internal return-address stack with RAS_DEPTH entries, circular pointer and saturating count.
  - Push id_pc+1 at an edge where id_valid = 1, stall = 0 and id_instr opcode = CALL.
  - Pop at an edge where id_valid = 1, stall = 0 and opcode = RET.
  - Push when full overwrites the oldest entry; count stays at RAS_DEPTH.
  - Pop when empty uses ret_addr, leaves the stack empty and raises ras_miss.
- FETCH_RAS_EN undefined:
  - No stack logic.
  - pc_src = 3 always selects ret_addr.
  - ras_miss is tied to 0.

## Structure
- Shared package holds:
  - Opcode constants (JMP, CALL, RET, branch opcodes).
  - PC_SRC encodings: PCSRC_SEQ = 0, PCSRC_JMP = 1, PCSRC_BR = 2, PCSRC_RET = 3.
  - PC_W and INSTR_W defaults.
- One sub-module, return_addr_stack (push, pop, push_data, top, empty, full), instantiated only under FETCH_RAS_EN.

## Test plan
- Reset, then run 4 cycles with imem returning 0x1000+addr. Required: imem_addr 0,1,2,3; id_pc 0,1,2 with id_valid = 1 from the first post-reset edge.
- Branch redirect: at PC = 5, apply kill = 1, pc_src = 2, branch_target = 0x0040. Required: next cycle id_valid = 0 and imem_addr = 0x0040; the cycle after, id_pc = 0x0040.
- Stall for 3 cycles while ID holds PC 7, with kill = 1 asserted during the stall. Required: imem_addr, id_pc = 7 and id_valid are all unchanged and no redirect occurs. After stall drops, fetch resumes at 9 (IF already held 8).
- Wrap: preload PC = 0xFFFF. Required: next imem_addr = 0x0000.
- RAS (FETCH_RAS_EN): CALL at 0x0010 to 0x0100, then RET in ID with ret_addr = 0x5555. Required: PC <= 0x0011, ras_miss = 0.
- RAS stress: 9 nested CALLs then 9 RETs. Required: the first 8 RETs return the newest 8 addresses in LIFO order; the 9th RET uses ret_addr and ras_miss pulses once. Without the macro, every RET uses ret_addr.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: opcodes, next-PC select encodings
// and default widths of the 16-bit pipelined processor.
package fetch_stage_pkg;

  localparam int PC_W_DEF      = 16;
  localparam int INSTR_W_DEF   = 16;
  localparam int RAS_DEPTH_DEF = 8;

  // Opcode field is instr[15:12].
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;

  typedef enum logic [1:0] {
    PCSRC_SEQ = 2'd0,
    PCSRC_JMP = 2'd1,
    PCSRC_BR  = 2'd2,
    PCSRC_RET = 2'd3
  } pc_src_e;

  function automatic logic is_call(input logic [3:0] op);
    return op == OP_CALL;
  endfunction

  function automatic logic is_ret(input logic [3:0] op);
    return op == OP_RET;
  endfunction

endpackage

// File: rtl/fetch_stage_return_addr_stack.sv
// Return-address stack: circular buffer with a saturating occupancy count.
// A push when full overwrites the oldest entry, so the newest DEPTH return
// addresses are always retained. DEPTH must be a power of two.
module return_addr_stack
  import fetch_stage_pkg::*;
#(
  parameter int DEPTH = RAS_DEPTH_DEF,
  parameter int W     = PC_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // wr_ptr points at the next free slot; the top is the slot just below it.
  assign top   = mem_q[wr_ptr_q - PTR_W'(1)];
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // Next-state: push wins over pop (they never coincide from one ID opcode).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      if (!full) begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (pop && !empty) begin
      wr_ptr_d = wr_ptr_q - PTR_W'(1);
      count_d  = count_q - CNT_W'(1);
    end
  end

  // Stack registers with synchronous reset to empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register.
// Owns the PC, drives the instruction-memory address and hands each fetched
// instruction with its PC to decode. Edge priority: reset > stall > kill >
// sequential fetch. Define FETCH_RAS_EN to add a return-address stack that
// supplies RET targets; without it RET always uses ret_addr from R7.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int PC_W      = PC_W_DEF,
  parameter int INSTR_W   = INSTR_W_DEF,
  parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               kill,
  input  logic [1:0]         pc_src,
  input  logic [PC_W-1:0]    jump_target,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [PC_W-1:0]    ret_addr,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  output logic               id_valid,
  output logic               ras_miss
);

  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [PC_W-1:0]    id_pc_q, id_pc_d;
  logic               id_valid_q, id_valid_d;

  logic [PC_W-1:0]    pc_plus1;
  logic [PC_W-1:0]    ret_target;
  logic [PC_W-1:0]    redirect_pc;

  assign imem_addr = pc_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
  assign id_valid  = id_valid_q;

  // Wraps modulo 2^PC_W.
  assign pc_plus1 = pc_q + PC_W'(1);

`ifdef FETCH_RAS_EN
  logic [3:0]      id_op;
  logic            call_push;
  logic            ret_pop;
  logic [PC_W-1:0] ras_top;
  logic            ras_empty;
  logic            ras_full;
  logic            ras_miss_q, ras_miss_d;

  // CALL/RET act on the stack only when the ID instruction actually retires
  // this edge; a stalled instruction is re-resolved next cycle.
  assign id_op     = id_instr_q[INSTR_W-1 -: 4];
  assign call_push = id_valid_q && !stall && is_call(id_op);
  assign ret_pop   = id_valid_q && !stall && is_ret(id_op);

  return_addr_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (call_push),
    .pop       (ret_pop),
    .push_data (id_pc_q + PC_W'(1)),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

  assign ret_target = ras_empty ? ret_addr : ras_top;

  // Miss flag: a RET retired against an empty stack fell back to R7.
  always_comb begin
    ras_miss_d = ret_pop && ras_empty;
  end

  // Registered one-cycle miss pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      ras_miss_q <= 1'b0;
    end else begin
      ras_miss_q <= ras_miss_d;
    end
  end

  assign ras_miss = ras_miss_q;
`else
  assign ret_target = ret_addr;
  assign ras_miss   = 1'b0;
`endif

  // Redirect target selected by ID.
  always_comb begin
    redirect_pc = pc_plus1;
    unique case (pc_src_e'(pc_src))
      PCSRC_SEQ: redirect_pc = pc_plus1;
      PCSRC_JMP: redirect_pc = jump_target;
      PCSRC_BR:  redirect_pc = branch_target;
      PCSRC_RET: redirect_pc = ret_target;
      default:   redirect_pc = pc_plus1;
    endcase
  end

  // Next PC and IF/ID contents: stall holds, kill redirects and inserts a
  // bubble, otherwise fetch sequentially.
  always_comb begin
    pc_d       = pc_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;
    if (stall) begin
      pc_d       = pc_q;
    end else if (kill) begin
      pc_d       = redirect_pc;
      id_instr_d = '0;
      id_pc_d    = '0;
      id_valid_d = 1'b0;
    end else begin
      pc_d       = pc_plus1;
      id_instr_d = imem_data;
      id_pc_d    = pc_q;
      id_valid_d = 1'b1;
    end
  end

  // PC and IF/ID registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= '0;
      id_instr_q <= '0;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Instruction memory returns 0x1000+addr
// unless an override word is forced (used to place CALL/RET in the stream).
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        kill;
  logic [1:0]  pc_src;
  logic [15:0] jump_target;
  logic [15:0] branch_target;
  logic [15:0] ret_addr;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic        id_valid;
  logic        ras_miss;

  logic        ovr_en;
  logic [15:0] ovr_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_data = ovr_en ? ovr_data : (16'h1000 + imem_addr);

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .stall         (stall),
    .kill          (kill),
    .pc_src        (pc_src),
    .jump_target   (jump_target),
    .branch_target (branch_target),
    .ret_addr      (ret_addr),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_valid      (id_valid),
    .ras_miss      (ras_miss)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Fetch a CALL at the current PC, then let ID redirect to target.
  task automatic call_at(input logic [15:0] target);
    ovr_en   = 1'b1;
    ovr_data = {OP_CALL, target[11:0]};
    step();
    ovr_en      = 1'b0;
    kill        = 1'b1;
    pc_src      = 2'd1;
    jump_target = target;
    step();
    kill        = 1'b0;
    chk("call_target", imem_addr, target);
  endtask

  // Fetch a RET at the current PC, redirect with pc_src=3, check target/miss.
  task automatic ret_check(input string tag, input logic [15:0] exp_pc, input logic exp_miss);
    ovr_en   = 1'b1;
    ovr_data = {OP_RET, 12'h000};
    step();
    ovr_en   = 1'b0;
    kill     = 1'b1;
    pc_src   = 2'd3;
    step();
    kill     = 1'b0;
    chk({tag, "_pc"}, imem_addr, exp_pc);
    chk({tag, "_miss"}, ras_miss, exp_miss);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; kill = 1'b0; pc_src = 2'd0;
    jump_target = '0; branch_target = '0; ret_addr = 16'h5555;
    ovr_en = 1'b0; ovr_data = '0;

    // Reset state
    step(); step();
    chk("rst_pc", imem_addr, 16'h0000);
    chk("rst_instr", id_instr, 16'h0000);
    chk("rst_id_pc", id_pc, 16'h0000);
    chk("rst_valid", id_valid, 1'b0);
    chk("rst_miss", ras_miss, 1'b0);
    reset = 1'b0;

    // Sequential fetch
    chk("seq_addr0", imem_addr, 16'h0000);
    step();
    chk("seq_addr1", imem_addr, 16'h0001);
    chk("seq_idpc0", id_pc, 16'h0000);
    chk("seq_valid0", id_valid, 1'b1);
    chk("seq_instr0", id_instr, 16'h1000);
    step();
    chk("seq_addr2", imem_addr, 16'h0002);
    chk("seq_idpc1", id_pc, 16'h0001);
    step();
    chk("seq_addr3", imem_addr, 16'h0003);
    chk("seq_idpc2", id_pc, 16'h0002);
    chk("seq_instr2", id_instr, 16'h1002);
    step(); step();
    chk("pre_br_pc", imem_addr, 16'h0005);

    // Branch redirect at PC 5
    kill = 1'b1; pc_src = 2'd2; branch_target = 16'h0040;
    step();
    kill = 1'b0; pc_src = 2'd0;
    chk("br_valid", id_valid, 1'b0);
    chk("br_instr", id_instr, 16'h0000);
    chk("br_addr", imem_addr, 16'h0040);
    step();
    chk("br_idpc", id_pc, 16'h0040);
    chk("br_valid2", id_valid, 1'b1);
    chk("br_instr2", id_instr, 16'h1040);

    // Stall with ID holding PC 7, kill asserted during stall is ignored
    kill = 1'b1; pc_src = 2'd1; jump_target = 16'h0006;
    step();
    kill = 1'b0; pc_src = 2'd0;
    step(); step();
    chk("st_pre_idpc", id_pc, 16'h0007);
    chk("st_pre_addr", imem_addr, 16'h0008);
    stall = 1'b1; kill = 1'b1; pc_src = 2'd1; jump_target = 16'h0300;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_addr", imem_addr, 16'h0008);
      chk("st_idpc", id_pc, 16'h0007);
      chk("st_valid", id_valid, 1'b1);
      chk("st_instr", id_instr, 16'h1007);
    end
    stall = 1'b0; kill = 1'b0; pc_src = 2'd0;
    step();
    chk("st_res_addr", imem_addr, 16'h0009);
    chk("st_res_idpc", id_pc, 16'h0008);
    chk("st_res_instr", id_instr, 16'h1008);
    step();
    chk("st_res_addr2", imem_addr, 16'h000A);
    chk("st_res_idpc2", id_pc, 16'h0009);

    // PC wrap at 0xFFFF
    kill = 1'b1; pc_src = 2'd1; jump_target = 16'hFFFF;
    step();
    kill = 1'b0; pc_src = 2'd0;
    chk("wrap_pre", imem_addr, 16'hFFFF);
    step();
    chk("wrap_addr", imem_addr, 16'h0000);
    chk("wrap_idpc", id_pc, 16'hFFFF);
    chk("wrap_instr", id_instr, 16'h0FFF);

    // pc_src without kill is ignored
    pc_src = 2'd2; branch_target = 16'h0777;
    step();
    pc_src = 2'd0;
    chk("nokill_addr", imem_addr, 16'h0001);

    // Reset asserted mid-stall wins
    stall = 1'b1; reset = 1'b1;
    step();
    stall = 1'b0; reset = 1'b0;
    chk("rst_st_pc", imem_addr, 16'h0000);
    chk("rst_st_valid", id_valid, 1'b0);
    chk("rst_st_idpc", id_pc, 16'h0000);

    // CALL at 0x0010 to 0x0100, then RET with ret_addr = 0x5555
    kill = 1'b1; pc_src = 2'd1; jump_target = 16'h0010;
    step();
    kill = 1'b0;
    chk("call_pre", imem_addr, 16'h0010);
    call_at(16'h0100);
`ifdef FETCH_RAS_EN
    ret_check("ret1", 16'h0011, 1'b0);
`else
    ret_check("ret1", 16'h5555, 1'b0);
`endif

    // Nine nested CALLs from 0x200, 0x210, ... then nine RETs
    kill = 1'b1; pc_src = 2'd1; jump_target = 16'h0200;
    step();
    kill = 1'b0;
    for (int k = 0; k < 9; k++) begin
      call_at(16'h0200 + 16'(16 * (k + 1)));
    end
    for (int i = 0; i < 9; i++) begin
`ifdef FETCH_RAS_EN
      if (i < 8) ret_check("nest_ret", 16'h0200 + 16'(16 * (8 - i)) + 16'h0001, 1'b0);
      else       ret_check("nest_ret_last", 16'h5555, 1'b1);
`else
      ret_check("nest_ret", 16'h5555, 1'b0);
`endif
    end
    step();
    chk("miss_pulse_end", ras_miss, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
